vga_frame_buffer: RTL and testbench

Double-buffered, clocked pixel frame store between the image-masking pipeline and the VGA scan-out logic. Generalises the single-bank, combinational pixel buffer RAM to parametrised geometry and pixel width, adds a valid/ready write handshake, a registered read port, and a bank swap synchronised to frame start. The scan-out side therefore never displays a partially written frame.

---
 rtl/vga_pkg.sv | 14 +
 rtl/vga_buffer_ram_dp.sv | 26 ++
 rtl/vga_frame_buffer.sv | 132 +++++++++++++
 tb/tb_vga_frame_buffer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared geometry defaults and write-side FSM state type for the
// double-buffered VGA frame store.
package vga_pkg;
    localparam int PIXEL_W = 12;
    localparam int ROWS    = 240;
    localparam int COLS    = 320;
    localparam int ROW_W   = 8;
    localparam int COL_W   = 9;

    typedef enum logic {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } fb_state_e;
endpackage

// File: rtl/vga_buffer_ram_dp.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read
// port, no reset on the array so it maps onto block RAM.
module vga_buffer_ram_dp #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Read data holds when i_re is low; the top relies on this.
    always_ff @(posedge clk) begin
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/vga_frame_buffer.sv
// Double-buffered pixel frame store: writer fills one bank while scan-out
// reads the other; banks swap on frame_start once a full frame is written.
module vga_frame_buffer #(
    parameter int                   PIXEL_W  = 12,
    parameter int                   ROWS     = 240,
    parameter int                   COLS     = 320,
    parameter int                   ROW_W    = 8,
    parameter int                   COL_W    = 9,
    parameter logic [PIXEL_W-1:0]   BG_COLOR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [PIXEL_W-1:0] pixel_result,
    input  logic [ROW_W-1:0]   pixel_row,
    input  logic [COL_W-1:0]   pixel_col,
    input  logic               wr_last,
    input  logic               frame_start,
    input  logic               rd_en,
    input  logic [ROW_W-1:0]   row_read,
    input  logic [COL_W-1:0]   col_read,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               rd_valid,
    output logic               wr_bank,
    output logic               wr_err,
    output logic [7:0]         drop_cnt
);
    import vga_pkg::*;

    localparam int FRAME = ROWS * COLS;
    localparam int DEPTH = 2 * FRAME;
    localparam int AW    = $clog2(DEPTH);

    fb_state_e          r_state, w_state_nxt;
    logic               r_wr_bank;
    logic               r_wr_err;
    logic [7:0]         r_drop_cnt;
    logic               r_rd_valid;
    logic               r_rd_oor;
    logic               r_rd_seen;

    logic               w_wr_fire;
    logic               w_wr_inrange;
    logic               w_rd_inrange;
    logic               w_swap;
    logic               w_drop;
    logic [AW-1:0]      w_wr_addr;
    logic [AW-1:0]      w_rd_addr;
    logic [PIXEL_W-1:0] w_ram_q;

    assign wr_ready     = (r_state == FILL);
    assign w_wr_fire    = wr_valid && wr_ready;
    assign w_wr_inrange = (int'(pixel_row) < ROWS) && (int'(pixel_col) < COLS);
    assign w_rd_inrange = (int'(row_read) < ROWS) && (int'(col_read) < COLS);

    // Addresses are only used when the range check passes, so every value
    // that reaches the RAM fits in AW bits.
    assign w_wr_addr = (r_wr_bank ? AW'(FRAME) : AW'(0))
                     + AW'(pixel_row) * AW'(COLS) + AW'(pixel_col);
    assign w_rd_addr = (r_wr_bank ? AW'(0) : AW'(FRAME))
                     + AW'(row_read) * AW'(COLS) + AW'(col_read);

    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            FILL: begin
                w_drop = frame_start;
                if (w_wr_fire && wr_last) w_state_nxt = WAIT_SWAP;
            end
            WAIT_SWAP: begin
                if (frame_start) begin
                    w_swap      = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FILL;
            r_wr_bank  <= 1'b0;
            r_wr_err   <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_swap) r_wr_bank <= ~r_wr_bank;
            if (w_wr_fire && !w_wr_inrange) r_wr_err <= 1'b1;
            if (w_drop) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    // r_rd_seen forces pixel_out to 0 until the first read after reset,
    // since the RAM output register itself is not reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_oor   <= 1'b0;
            r_rd_seen  <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_oor  <= !w_rd_inrange;
                r_rd_seen <= 1'b1;
            end
        end
    end

    vga_buffer_ram_dp #(
        .DEPTH (DEPTH),
        .WIDTH (PIXEL_W),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_fire && w_wr_inrange),
        .i_waddr (w_wr_addr),
        .i_wdata (pixel_result),
        .i_re    (rd_en && w_rd_inrange),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_q)
    );

    assign pixel_out = !r_rd_seen ? '0 : (r_rd_oor ? BG_COLOR : w_ram_q);
    assign rd_valid  = r_rd_valid;
    assign wr_bank   = r_wr_bank;
    assign wr_err    = r_wr_err;
    assign drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_vga_frame_buffer.sv
// Directed plus randomized bench for vga_frame_buffer, checked against a
// frame-level model (two banks as an associative pixel store).
module tb_vga_frame_buffer;
    localparam int         ROWS = 240;
    localparam int         COLS = 320;
    localparam logic [11:0] BG  = 12'hF0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0, wr_ready;
    logic [11:0] pixel_result = '0;
    logic [7:0]  pixel_row = '0;
    logic [8:0]  pixel_col = '0;
    logic        wr_last = 1'b0, frame_start = 1'b0, rd_en = 1'b0;
    logic [7:0]  row_read = '0;
    logic [8:0]  col_read = '0;
    logic [11:0] pixel_out;
    logic        rd_valid, wr_bank, wr_err;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    vga_frame_buffer #(.BG_COLOR(BG)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .pixel_result(pixel_result), .pixel_row(pixel_row), .pixel_col(pixel_col),
        .wr_last(wr_last), .frame_start(frame_start), .rd_en(rd_en),
        .row_read(row_read), .col_read(col_read), .pixel_out(pixel_out),
        .rd_valid(rd_valid), .wr_bank(wr_bank), .wr_err(wr_err), .drop_cnt(drop_cnt)
    );

    int n_chk = 0, n_fail = 0;

    // Model: bank contents, frame-complete flag, counters, last read result.
    logic [11:0] m_mem [int];
    bit          m_bank, m_wait, m_err, m_rdv, m_pix_known;
    logic [7:0]  m_drop;
    logic [11:0] m_pix;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int key(input bit b, input int r, input int c);
        return b * ROWS * COLS + r * COLS + c;
    endfunction

    task automatic model_reset();
        m_bank = 0; m_wait = 0; m_err = 0; m_rdv = 0;
        m_drop = 0; m_pix = 0; m_pix_known = 1;
    endtask

    task automatic cyc(input bit wv, input logic [11:0] d, input int r, input int c,
                       input bit last, input bit fs, input bit re, input int rr, input int rc);
        bit w0;
        wr_valid = wv; pixel_result = d; pixel_row = 8'(r); pixel_col = 9'(c);
        wr_last = last; frame_start = fs; rd_en = re; row_read = 8'(rr); col_read = 9'(rc);
        w0 = m_wait;
        m_rdv = re;
        if (re) begin
            if (rr < ROWS && rc < COLS) begin
                m_pix_known = m_mem.exists(key(!m_bank, rr, rc));
                if (m_pix_known) m_pix = m_mem[key(!m_bank, rr, rc)];
            end else begin
                m_pix = BG; m_pix_known = 1;
            end
        end
        if (wv && !w0) begin
            if (r < ROWS && c < COLS) m_mem[key(m_bank, r, c)] = d;
            else m_err = 1;
            if (last) m_wait = 1;
        end
        if (fs) begin
            if (!w0) m_drop++;
            else begin m_bank = !m_bank; m_wait = 0; end
        end
        @(posedge clk); #1;
        chk("wr_ready", wr_ready, !m_wait);
        chk("wr_bank", wr_bank, m_bank);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("wr_err", wr_err, m_err);
        chk("rd_valid", rd_valid, m_rdv);
        if (m_pix_known) chk("pixel_out", pixel_out, m_pix);
    endtask

    task automatic wr(input logic [11:0] d, input int r, input int c, input bit last);
        cyc(1, d, r, c, last, 0, 0, 0, 0);
    endtask
    task automatic rd(input int r, input int c);
        cyc(0, 0, 0, 0, 0, 0, 1, r, c);
    endtask
    task automatic fs();
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    function automatic int rnd_row();
        return ($urandom_range(0, 19) == 0) ? int'($urandom_range(240, 255)) : int'($urandom_range(0, 7));
    endfunction
    function automatic int rnd_col();
        return ($urandom_range(0, 19) == 0) ? int'($urandom_range(320, 511)) : int'($urandom_range(0, 7));
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_wr_bank", wr_bank, 0);
        chk("rst_pixel_out", pixel_out, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_wr_err", wr_err, 0);

        // First frame into bank 0, swap, read it back.
        wr(12'hAAA, 0, 0, 0);
        wr(12'hBBB, 5, 3, 0);
        wr(12'hCCC, 2, 7, 1);
        fs();
        rd(5, 3);  chk("rd_bbb", pixel_out, 12'hBBB);
        rd(2, 7);  chk("rd_ccc", pixel_out, 12'hCCC);
        chk("bank_after_swap", wr_bank, 1);

        // Second frame into bank 1; writer stalls after wr_last.
        wr(12'h123, 5, 3, 0);
        wr(12'h321, 0, 0, 0);
        rd(5, 3);  chk("rd_old_frame", pixel_out, 12'hBBB);
        wr(12'h456, 1, 1, 1);
        wr(12'h999, 5, 3, 0);  chk("stall_ready", wr_ready, 0);
        wr(12'h999, 5, 3, 0);
        rd(5, 3);  chk("rd_still_old", pixel_out, 12'hBBB);
        fs();
        rd(5, 3);  chk("rd_new_frame", pixel_out, 12'h123);

        // frame_start while filling only counts drops.
        fs(); fs(); fs();
        chk("drop3", drop_cnt, 3);
        chk("drop_no_swap", wr_bank, 0);

        // Out-of-range writes must not alias into the other bank.
        wr(12'h555, 240, 0, 0);
        wr(12'h555, 0, 320, 0);
        chk("wr_err_set", wr_err, 1);
        rd(0, 0);   chk("no_alias", pixel_out, 12'h321);
        rd(0, 320); chk("rd_bg_col", pixel_out, BG);
        rd(240, 0); chk("rd_bg_row", pixel_out, BG);
        rd(5, 3);   rd(0, 320);

        // wr_last and frame_start together: no swap, next frame_start swaps.
        cyc(1, 12'h777, 0, 0, 1, 1, 0, 0, 0);
        chk("drop4", drop_cnt, 4);
        chk("same_cycle_no_swap", wr_bank, 0);
        fs();
        chk("late_swap", wr_bank, 1);
        rd(0, 0);   chk("rd_777", pixel_out, 12'h777);

        // Reset mid-frame while waiting to swap with a read in flight.
        wr(12'h0F0, 3, 3, 1);
        rd(0, 0);
        rd_en = 0; wr_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_bank", wr_bank, 0);
        chk("mid_rst_ready", wr_ready, 1);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_pixel", pixel_out, 0);
        chk("mid_rst_err", wr_err, 0);
        model_reset();
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, 12'($urandom), rnd_row(), rnd_col(),
                $urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0,
                $urandom_range(0, 1) == 1, rnd_row(), rnd_col());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
